// File: rtl/tx_bit_stuffer_if.sv
// Handshake and line signals between the TX byte shifter, the bit stuffer and the pads.
interface tx_bit_stuffer_if;
    logic bit_strobe;
    logic tx_bit;
    logic tx_bit_valid;
    logic eop_req;
    logic bit_taken;
    logic dplus_out;
    logic dminus_out;
    logic tx_busy;
    logic eop_done;
    logic tx_error;

    modport master (
        output bit_strobe, tx_bit, tx_bit_valid, eop_req,
        input  bit_taken, dplus_out, dminus_out, tx_busy, eop_done, tx_error
    );

    modport slave (
        input  bit_strobe, tx_bit, tx_bit_valid, eop_req,
        output bit_taken, dplus_out, dminus_out, tx_busy, eop_done, tx_error
    );
endinterface

// File: rtl/tx_bit_stuffer.sv
// USB full-speed TX line encoder: bit stuffing after six 1s, NRZI onto D+/D-, and EOP generation.
//   state | meaning
//   IDLE  | line J, waiting for the first valid bit
//   DATA  | sending data bits and stuffed zeros
//   EOP1  | first SE0 on the line, next strobe drives the second SE0
//   EOP2  | second SE0 on the line, next strobe drives J
//   EOPJ  | final J on the line, next clock pulses eop_done
module tx_bit_stuffer (
    input  logic            clk,
    input  logic            n_rst,
    tx_bit_stuffer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DATA = 3'd1,
        EOP1 = 3'd2,
        EOP2 = 3'd3,
        EOPJ = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_ones_cnt;
    logic [2:0] w_ones_nxt;
    logic       r_level;
    logic       w_level_nxt;
    logic       r_dplus;
    logic       w_dplus_nxt;
    logic       r_dminus;
    logic       w_dminus_nxt;
    logic       r_busy;
    logic       w_busy_nxt;
    logic       r_eop_done;
    logic       w_eop_done_nxt;
    logic       r_tx_error;
    logic       w_tx_error_nxt;
    logic       w_bit_taken;

    // r_level is the NRZI level (1 = J, 0 = K); it survives SE0 so the next packet starts from J.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= IDLE;
            r_ones_cnt <= 3'd0;
            r_level    <= 1'b1;
            r_dplus    <= 1'b1;
            r_dminus   <= 1'b0;
            r_busy     <= 1'b0;
            r_eop_done <= 1'b0;
            r_tx_error <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ones_cnt <= w_ones_nxt;
            r_level    <= w_level_nxt;
            r_dplus    <= w_dplus_nxt;
            r_dminus   <= w_dminus_nxt;
            r_busy     <= w_busy_nxt;
            r_eop_done <= w_eop_done_nxt;
            r_tx_error <= w_tx_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ones_nxt     = r_ones_cnt;
        w_level_nxt    = r_level;
        w_dplus_nxt    = r_dplus;
        w_dminus_nxt   = r_dminus;
        w_busy_nxt     = r_busy;
        w_eop_done_nxt = 1'b0;
        w_tx_error_nxt = 1'b0;
        w_bit_taken    = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.bit_strobe && bus.tx_bit_valid) begin
                    w_bit_taken  = 1'b1;
                    w_level_nxt  = bus.tx_bit ? r_level : ~r_level;
                    w_dplus_nxt  = w_level_nxt;
                    w_dminus_nxt = ~w_level_nxt;
                    w_ones_nxt   = bus.tx_bit ? 3'd1 : 3'd0;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = DATA;
                end
            end
            DATA: begin
                if (bus.bit_strobe) begin
                    if (r_ones_cnt == 3'd6) begin
                        w_level_nxt  = ~r_level;
                        w_dplus_nxt  = w_level_nxt;
                        w_dminus_nxt = ~w_level_nxt;
                        w_ones_nxt   = 3'd0;
                    end else if (bus.tx_bit_valid) begin
                        w_bit_taken  = 1'b1;
                        w_level_nxt  = bus.tx_bit ? r_level : ~r_level;
                        w_dplus_nxt  = w_level_nxt;
                        w_dminus_nxt = ~w_level_nxt;
                        w_ones_nxt   = bus.tx_bit ? (r_ones_cnt + 3'd1) : 3'd0;
                    end else begin
                        // Underrun aborts the packet with an ordinary EOP.
                        w_tx_error_nxt = ~bus.eop_req;
                        w_dplus_nxt    = 1'b0;
                        w_dminus_nxt   = 1'b0;
                        w_state_nxt    = EOP1;
                    end
                end
            end
            EOP1: begin
                if (bus.bit_strobe) begin
                    w_dplus_nxt  = 1'b0;
                    w_dminus_nxt = 1'b0;
                    w_state_nxt  = EOP2;
                end
            end
            EOP2: begin
                if (bus.bit_strobe) begin
                    w_level_nxt  = 1'b1;
                    w_dplus_nxt  = 1'b1;
                    w_dminus_nxt = 1'b0;
                    w_state_nxt  = EOPJ;
                end
            end
            EOPJ: begin
                w_eop_done_nxt = 1'b1;
                w_busy_nxt     = 1'b0;
                w_ones_nxt     = 3'd0;
                w_state_nxt    = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Gated with reset so the shifter never advances while the encoder is held in reset.
    assign bus.bit_taken  = w_bit_taken & n_rst;
    assign bus.dplus_out  = r_dplus;
    assign bus.dminus_out = r_dminus;
    assign bus.tx_busy    = r_busy;
    assign bus.eop_done   = r_eop_done;
    assign bus.tx_error   = r_tx_error;

endmodule

// File: tb/tb_tx_bit_stuffer.sv
// Randomized bench for tx_bit_stuffer against a bit-stream model of stuffing, NRZI and EOP.
module tb_tx_bit_stuffer;

    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    bit         pkt[$];
    logic [1:0] exp_sym[$];
    bit         exp_take[$];

    always #5 clk = ~clk;

    tx_bit_stuffer_if bus ();

    tx_bit_stuffer dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] line_now();
        return {bus.dplus_out, bus.dminus_out};
    endfunction

    // Expected per-strobe line symbols and consumption flags for the bits in pkt.
    task automatic build_expect();
        bit lvl;
        int ones;
        lvl  = 1'b1;
        ones = 0;
        exp_sym.delete();
        exp_take.delete();
        for (int i = 0; i < pkt.size(); i++) begin
            if (!pkt[i]) lvl = ~lvl;
            exp_sym.push_back(lvl ? SYM_J : SYM_K);
            exp_take.push_back(1'b1);
            ones = pkt[i] ? ones + 1 : 0;
            if (ones == 6) begin
                lvl = ~lvl;
                exp_sym.push_back(lvl ? SYM_J : SYM_K);
                exp_take.push_back(1'b0);
                ones = 0;
            end
        end
        exp_sym.push_back(SYM_SE0); exp_take.push_back(1'b0);
        exp_sym.push_back(SYM_SE0); exp_take.push_back(1'b0);
        exp_sym.push_back(SYM_J);   exp_take.push_back(1'b0);
    endtask

    task automatic run_packet(input bit underrun);
        int  nd;
        int  idx;
        bit  exp_err;
        build_expect();
        nd  = exp_sym.size() - 3;
        idx = 0;
        check_val("idle_line", line_now(), SYM_J);
        check_val("idle_busy", {1'b0, bus.tx_busy}, 2'd0);
        for (int k = 0; k < exp_sym.size(); k++) begin
            if (k > 0) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                    check_val("gap_hold", line_now(), exp_sym[k-1]);
                    check_val("gap_err", {1'b0, bus.tx_error}, 2'd0);
                end
            end
            @(negedge clk);
            bus.bit_strobe = 1'b1;
            exp_err = 1'b0;
            if (k < nd) begin
                bus.tx_bit_valid = (idx < pkt.size());
                bus.tx_bit       = bus.tx_bit_valid ? pkt[idx] : 1'($urandom);
                bus.eop_req      = 1'($urandom);
            end else if (k == nd) begin
                bus.tx_bit_valid = 1'b0;
                bus.tx_bit       = 1'($urandom);
                bus.eop_req      = ~underrun;
                exp_err          = underrun;
            end else begin
                bus.tx_bit_valid = 1'($urandom);
                bus.tx_bit       = 1'($urandom);
                bus.eop_req      = 1'($urandom);
            end
            #1;
            check_val("bit_taken", {1'b0, bus.bit_taken}, {1'b0, exp_take[k]});
            if (exp_take[k]) idx++;
            @(posedge clk); #1;
            bus.bit_strobe   = 1'b0;
            bus.tx_bit_valid = 1'b0;
            bus.eop_req      = 1'b0;
            check_val("line", line_now(), exp_sym[k]);
            check_val("busy", {1'b0, bus.tx_busy}, 2'd1);
            check_val("tx_error", {1'b0, bus.tx_error}, {1'b0, exp_err});
            check_val("eop_done_early", {1'b0, bus.eop_done}, 2'd0);
        end
        check_val("bits_consumed", (idx == pkt.size()) ? 2'd1 : 2'd0, 2'd1);
        @(posedge clk); #1;
        check_val("eop_done", {1'b0, bus.eop_done}, 2'd1);
        check_val("busy_fall", {1'b0, bus.tx_busy}, 2'd0);
        check_val("eop_line_j", line_now(), SYM_J);
        @(posedge clk); #1;
        check_val("eop_done_pulse", {1'b0, bus.eop_done}, 2'd0);
        check_val("post_line_j", line_now(), SYM_J);
    endtask

    initial begin
        bus.bit_strobe   = 1'b0;
        bus.tx_bit       = 1'b0;
        bus.tx_bit_valid = 1'b0;
        bus.eop_req      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_line", line_now(), SYM_J);
        check_val("rst_busy", {1'b0, bus.tx_busy}, 2'd0);
        check_val("rst_done", {1'b0, bus.eop_done}, 2'd0);
        check_val("rst_err", {1'b0, bus.tx_error}, 2'd0);
        @(negedge clk);
        n_rst = 1'b1;

        // eop_req alone in IDLE is ignored
        repeat (3) begin
            @(negedge clk);
            bus.bit_strobe = 1'b1;
            bus.eop_req    = 1'b1;
            #1;
            check_val("idle_eop_taken", {1'b0, bus.bit_taken}, 2'd0);
            @(posedge clk); #1;
            bus.bit_strobe = 1'b0;
            check_val("idle_eop_line", line_now(), SYM_J);
            check_val("idle_eop_busy", {1'b0, bus.tx_busy}, 2'd0);
        end
        bus.eop_req = 1'b0;

        // Start a packet, then reset asynchronously in the middle of it
        repeat (4) begin
            @(negedge clk);
            bus.bit_strobe   = 1'b1;
            bus.tx_bit_valid = 1'b1;
            bus.tx_bit       = 1'b0;
            @(posedge clk); #1;
            bus.bit_strobe = 1'b0;
        end
        check_val("mid_busy", {1'b0, bus.tx_busy}, 2'd1);
        @(negedge clk);
        bus.bit_strobe = 1'b1;
        #2;
        n_rst = 1'b0;
        #1;
        check_val("arst_line", line_now(), SYM_J);
        check_val("arst_busy", {1'b0, bus.tx_busy}, 2'd0);
        check_val("arst_taken", {1'b0, bus.bit_taken}, 2'd0);
        check_val("arst_err", {1'b0, bus.tx_error}, 2'd0);
        check_val("arst_done", {1'b0, bus.eop_done}, 2'd0);
        @(posedge clk); #1;
        check_val("arst_hold_line", line_now(), SYM_J);
        bus.bit_strobe   = 1'b0;
        bus.tx_bit_valid = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Sync pattern followed by eight 1s
        pkt.delete();
        for (int i = 0; i < 7; i++) pkt.push_back(1'b0);
        for (int i = 0; i < 9; i++) pkt.push_back(1'b1);
        run_packet(1'b0);

        // Exactly six 1s: the stuffed toggle must precede the EOP
        pkt.delete();
        for (int i = 0; i < 6; i++) pkt.push_back(1'b1);
        run_packet(1'b0);

        // Same ending, but aborted by underrun
        pkt.delete();
        pkt.push_back(1'b0);
        for (int i = 0; i < 6; i++) pkt.push_back(1'b1);
        run_packet(1'b1);

        // Short underrun packet
        pkt.delete();
        pkt.push_back(1'b0);
        pkt.push_back(1'b1);
        run_packet(1'b1);

        for (int p = 0; p < 40; p++) begin
            int len;
            pkt.delete();
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) pkt.push_back($urandom_range(0, 3) != 0);
            run_packet(1'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
